load_store_unit: RTL

Multi-cycle load/store unit between the CPU datapath and a word-organised data memory. The CPU side sends the ALU result address, rs2 data and funct3. The unit performs LB/LH/LW/LBU/LHU and SB/SH/SW. Sub-word stores use read-modify-write, because the memory has no byte enables. The unit stalls the CPU through busy until the access completes, and flags misaligned or illegal accesses without touching memory.

---
 rtl/load_store_unit_if.sv | 43 ++++
 rtl/load_store_unit.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : load_store_unit_if
// Purpose  : Bundles the CPU request/response signals and the data-memory
//            bus of the load/store unit into one interface.
// Ports    : none (signals only)
//   CPU side    : req_read, req_write, funct3, addr, wdata  -> unit
//                 busy, done, rdata, fault                   <- unit
//   Memory side : mem_en, mem_we, mem_addr, mem_wdata        <- unit
//                 mem_rdata                                   -> unit
// Modports : master - the environment (CPU datapath plus data memory)
//            slave  - the load/store unit itself
// Revision : 1.0 - initial release
// ============================================================================
interface load_store_unit_if #(
    parameter int MEM_ADDR_W = 6
);
    logic                  req_read;
    logic                  req_write;
    logic [2:0]            funct3;
    logic [31:0]           addr;
    logic [31:0]           wdata;
    logic                  busy;
    logic                  done;
    logic [31:0]           rdata;
    logic                  fault;
    logic                  mem_en;
    logic                  mem_we;
    logic [MEM_ADDR_W-1:0] mem_addr;
    logic [31:0]           mem_wdata;
    logic [31:0]           mem_rdata;

    modport master (
        output req_read, req_write, funct3, addr, wdata, mem_rdata,
        input  busy, done, rdata, fault, mem_en, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  req_read, req_write, funct3, addr, wdata, mem_rdata,
        output busy, done, rdata, fault, mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : load_store_unit
// Purpose  : Multi-cycle load/store unit between the CPU datapath and a
//            word-organised data memory without byte enables. Performs
//            LB/LH/LW/LBU/LHU and SB/SH/SW; sub-word stores are done as
//            read-modify-write. Stalls the CPU through busy and reports
//            misaligned or illegal accesses through fault without touching
//            memory.
// Ports    : clk  - clock, rising edge
//            rst  - synchronous active-high reset
//            bus  - load_store_unit_if.slave (CPU request/response and
//                   data-memory bus)
// Revision : 1.0 - initial release
// ============================================================================
module load_store_unit #(
    parameter int MEM_ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    load_store_unit_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RD      = 3'd1,
        S_RD_WAIT = 3'd2,
        S_WR      = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    localparam logic [1:0] C_SIZE_HALF = 2'b01;
    localparam logic [1:0] C_SIZE_WORD = 2'b10;

    state_t                state_q,     state_d;
    logic                  done_q,      done_d;
    logic                  fault_q,     fault_d;
    logic [31:0]           rdata_q,     rdata_d;
    logic                  mem_en_q,    mem_en_d;
    logic                  mem_we_q,    mem_we_d;
    logic [MEM_ADDR_W-1:0] mem_addr_q,  mem_addr_d;
    logic [31:0]           mem_wdata_q, mem_wdata_d;

    // Request attributes captured at acceptance
    logic [1:0]            byte_off_q,  byte_off_d;
    logic [2:0]            funct3_q,    funct3_d;
    logic [15:0]           wdata_lo_q,  wdata_lo_d;
    logic                  is_store_q,  is_store_d;

    logic                  w_req;
    logic                  w_legal;
    logic                  w_misaligned;
    logic                  w_fault;
    logic [7:0]            w_byte;
    logic [15:0]           w_half;
    logic [31:0]           w_load_val;
    logic [31:0]           w_merged;

    // ------------------------------------------------------------------
    // Decode of the incoming request (only meaningful in IDLE)
    // ------------------------------------------------------------------
    always_comb begin
        w_req        = bus.req_read | bus.req_write;
        w_legal      = 1'b0;
        w_misaligned = 1'b0;
        // A simultaneous read and write request is handled as a store
        if (bus.req_write) begin
            w_legal = (bus.funct3 == 3'b000) || (bus.funct3 == 3'b001) ||
                      (bus.funct3 == 3'b010);
        end else begin
            w_legal = (bus.funct3 == 3'b000) || (bus.funct3 == 3'b001) ||
                      (bus.funct3 == 3'b010) || (bus.funct3 == 3'b100) ||
                      (bus.funct3 == 3'b101);
        end
        case (bus.funct3[1:0])
            C_SIZE_HALF: w_misaligned = bus.addr[0];
            C_SIZE_WORD: w_misaligned = (bus.addr[1:0] != 2'b00);
            default:     w_misaligned = 1'b0;
        endcase
        w_fault = !w_legal || w_misaligned;
    end

    // ------------------------------------------------------------------
    // Read-data path: load extraction and sub-word store merge
    // ------------------------------------------------------------------
    always_comb begin
        w_byte = bus.mem_rdata[{byte_off_q, 3'b000} +: 8];
        w_half = byte_off_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];

        case (funct3_q)
            3'b000:  w_load_val = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_load_val = {{16{w_half[15]}}, w_half};
            3'b100:  w_load_val = {24'd0, w_byte};
            3'b101:  w_load_val = {16'd0, w_half};
            default: w_load_val = bus.mem_rdata;
        endcase

        // funct3[0] distinguishes SH (1) from SB (0) for sub-word stores
        w_merged = bus.mem_rdata;
        if (funct3_q[0]) begin
            if (byte_off_q[1]) begin
                w_merged[31:16] = wdata_lo_q;
            end else begin
                w_merged[15:0]  = wdata_lo_q;
            end
        end else begin
            w_merged[{byte_off_q, 3'b000} +: 8] = wdata_lo_q[7:0];
        end
    end

    // ------------------------------------------------------------------
    // Next-state and registered-output logic. Outputs are computed from
    // the state being entered so that they are valid for the whole of
    // that state.
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        done_d      = 1'b0;
        fault_d     = 1'b0;
        rdata_d     = rdata_q;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        byte_off_d  = byte_off_q;
        funct3_d    = funct3_q;
        wdata_lo_d  = wdata_lo_q;
        is_store_d  = is_store_q;

        case (state_q)
            S_IDLE: begin
                if (w_req) begin
                    byte_off_d = bus.addr[1:0];
                    funct3_d   = bus.funct3;
                    wdata_lo_d = bus.wdata[15:0];
                    is_store_d = bus.req_write;
                    if (w_fault) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        fault_d = 1'b1;
                    end else if (bus.req_write &&
                                 (bus.funct3[1:0] == C_SIZE_WORD)) begin
                        // Full-word store needs no read
                        state_d     = S_WR;
                        mem_en_d    = 1'b1;
                        mem_we_d    = 1'b1;
                        mem_addr_d  = bus.addr[MEM_ADDR_W+1:2];
                        mem_wdata_d = bus.wdata;
                    end else begin
                        // Loads and sub-word stores start with a read
                        state_d    = S_RD;
                        mem_en_d   = 1'b1;
                        mem_addr_d = bus.addr[MEM_ADDR_W+1:2];
                    end
                end
            end
            S_RD: begin
                state_d = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                if (is_store_q) begin
                    state_d     = S_WR;
                    mem_en_d    = 1'b1;
                    mem_we_d    = 1'b1;
                    mem_wdata_d = w_merged;
                end else begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    rdata_d = w_load_val;
                end
            end
            S_WR: begin
                state_d = S_DONE;
                done_d  = 1'b1;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            done_q      <= 1'b0;
            fault_q     <= 1'b0;
            rdata_q     <= 32'd0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 32'd0;
            byte_off_q  <= 2'd0;
            funct3_q    <= 3'd0;
            wdata_lo_q  <= 16'd0;
            is_store_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            done_q      <= done_d;
            fault_q     <= fault_d;
            rdata_q     <= rdata_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            byte_off_q  <= byte_off_d;
            funct3_q    <= funct3_d;
            wdata_lo_q  <= wdata_lo_d;
            is_store_q  <= is_store_d;
        end
    end

    // busy rises combinationally with the request so the CPU stalls in the
    // acceptance cycle; it is low in DONE so the CPU advances as DONE ends.
    assign bus.busy = ((state_q == S_IDLE) && w_req && !rst) ||
                      (state_q == S_RD) || (state_q == S_RD_WAIT) ||
                      (state_q == S_WR);

    assign bus.done      = done_q;
    assign bus.fault     = fault_q;
    assign bus.rdata     = rdata_q;
    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;

endmodule
`default_nettype wire
